// File: rtl/line_mem_arbiter_pkg.sv
// rtl/line_mem_arbiter_pkg.sv - shared types and constants for the line memory arbiter
// Contents: default widths, FSM state encoding, requester ids.
package line_mem_arbiter_pkg;

    localparam int LINE_W_DEF = 64;
    localparam int ADDR_W_DEF = 16;
    localparam int WD_W       = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic GNT_IC = 1'b0;
    localparam logic GNT_DC = 1'b1;

endpackage

// File: rtl/line_mem_arbiter_rr_arb2.sv
// rtl/line_mem_arbiter_rr_arb2.sv - two-way round-robin picker with last-grant flop
// Ports:
//   clk, reset_n      clock, async active-low reset (last grant resets to IC)
//   req_ic_i/req_dc_i requests from the two cache paths
//   grant_i           commit the current pick as the new last grant
//   gnt_o             current pick (GNT_IC / GNT_DC)
module line_mem_arbiter_rr_arb2
    import line_mem_arbiter_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic req_ic_i,
    input  logic req_dc_i,
    input  logic grant_i,
    output logic gnt_o
);

    logic last_q;

    // On a tie the requester that did not win last time is picked.
    always_comb begin
        gnt_o = GNT_IC;
        if (req_ic_i && req_dc_i) begin
            gnt_o = ~last_q;
        end else if (req_dc_i) begin
            gnt_o = GNT_DC;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q <= GNT_IC;
        end else if (grant_i) begin
            last_q <= gnt_o;
        end
    end

endmodule

// File: rtl/line_mem_arbiter.sv
// rtl/line_mem_arbiter.sv - shares the 4-word memory line port between I-cache and D-cache
// Ports:
//   clk, reset_n                  clock, async active-low reset
//   ic_req/ic_addr/ic_done/ic_rdata              I-cache line read channel
//   dc_req/dc_we/dc_addr/dc_wdata/dc_done/dc_rdata D-cache line read/write channel
//   m_readM/m_writeM/m_address/m_data            memory request side (m_data tristate)
//   m_readyM/m_input_readyM/m_doneM              memory status
//   err                           sticky watchdog / protocol error flag
module line_mem_arbiter
    import line_mem_arbiter_pkg::*;
#(
    parameter int LINE_W  = LINE_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int TIMEOUT = 31
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ic_req,
    input  logic [ADDR_W-1:0] ic_addr,
    output logic              ic_done,
    output logic [LINE_W-1:0] ic_rdata,
    input  logic              dc_req,
    input  logic              dc_we,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [LINE_W-1:0] dc_wdata,
    output logic              dc_done,
    output logic [LINE_W-1:0] dc_rdata,
    output logic              m_readM,
    output logic              m_writeM,
    output logic [ADDR_W-1:0] m_address,
    inout  wire  [LINE_W-1:0] m_data,
    input  logic              m_readyM,
    input  logic              m_input_readyM,
    input  logic              m_doneM,
    output logic              err
);

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              gnt_q, gnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic [LINE_W-1:0] ic_rdata_q, ic_rdata_d;
    logic [LINE_W-1:0] dc_rdata_q, dc_rdata_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              err_q, err_d;
    logic              arb_gnt;
    logic              grant;
    logic              unused_addr_lsbs;

    line_mem_arbiter_rr_arb2 u_arb (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_ic_i (ic_req),
        .req_dc_i (dc_req),
        .grant_i  (grant),
        .gnt_o    (arb_gnt)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        ic_rdata_d = ic_rdata_q;
        dc_rdata_d = dc_rdata_q;
        wd_d       = wd_q;
        err_d      = err_q;
        grant      = 1'b0;
        case (state_q)
            // Gating on m_readyM also covers a memory still draining a
            // transaction that was cut short by reset.
            ST_IDLE: begin
                if ((ic_req || dc_req) && m_readyM) begin
                    grant   = 1'b1;
                    gnt_d   = arb_gnt;
                    state_d = ST_ISSUE;
                    if (arb_gnt == GNT_DC) begin
                        we_d    = dc_we;
                        addr_d  = dc_addr;
                        wdata_d = dc_wdata;
                    end else begin
                        we_d    = 1'b0;
                        addr_d  = ic_addr;
                    end
                end
            end
            // Memory takes the request on the falling edge; readyM low at
            // the next rising edge is the acceptance.
            ST_ISSUE: begin
                if (!m_readyM) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                wd_d = wd_q + 1'b1;
                if (m_doneM) begin
                    state_d = ST_RESP;
                    if (!we_q) begin
                        if (m_input_readyM) begin
                            if (gnt_q == GNT_DC) begin
                                dc_rdata_d = m_data;
                            end else begin
                                ic_rdata_d = m_data;
                            end
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end else if (wd_q == WD_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                wd_d    = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= GNT_IC;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            ic_rdata_q <= '0;
            dc_rdata_q <= '0;
            wd_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            ic_rdata_q <= ic_rdata_d;
            dc_rdata_q <= dc_rdata_d;
            wd_q       <= wd_d;
            err_q      <= err_d;
        end
    end

    assign m_readM   = (state_q == ST_ISSUE) && !we_q;
    assign m_writeM  = (state_q == ST_ISSUE) && we_q;
    assign m_address = {addr_q[ADDR_W-1:2], 2'b00};
    assign m_data    = m_writeM ? wdata_q : {LINE_W{1'bz}};

    assign ic_done  = (state_q == ST_RESP) && (gnt_q == GNT_IC);
    assign dc_done  = (state_q == ST_RESP) && (gnt_q == GNT_DC);
    assign ic_rdata = ic_rdata_q;
    assign dc_rdata = dc_rdata_q;
    assign err      = err_q;

    // Word offset within the line is irrelevant to a line transfer.
    assign unused_addr_lsbs = ^addr_q[1:0];

endmodule

// File: tb/tb_line_mem_arbiter.sv
// tb/tb_line_mem_arbiter.sv - self-checking bench for line_mem_arbiter with a 4-cycle line memory model
module tb_line_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        ic_req = 1'b0;
    logic [15:0] ic_addr = '0;
    logic        ic_done;
    logic [63:0] ic_rdata;
    logic        dc_req = 1'b0;
    logic        dc_we = 1'b0;
    logic [15:0] dc_addr = '0;
    logic [63:0] dc_wdata = '0;
    logic        dc_done;
    logic [63:0] dc_rdata;
    logic        m_readM, m_writeM;
    logic [15:0] m_address;
    wire  [63:0] m_data;
    logic        m_readyM = 1'b1;
    logic        m_input_readyM = 1'b0;
    logic        m_doneM = 1'b0;
    logic        err;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    line_mem_arbiter dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .ic_req         (ic_req),
        .ic_addr        (ic_addr),
        .ic_done        (ic_done),
        .ic_rdata       (ic_rdata),
        .dc_req         (dc_req),
        .dc_we          (dc_we),
        .dc_addr        (dc_addr),
        .dc_wdata       (dc_wdata),
        .dc_done        (dc_done),
        .dc_rdata       (dc_rdata),
        .m_readM        (m_readM),
        .m_writeM       (m_writeM),
        .m_address      (m_address),
        .m_data         (m_data),
        .m_readyM       (m_readyM),
        .m_input_readyM (m_input_readyM),
        .m_doneM        (m_doneM),
        .err            (err)
    );

    // Line memory model: accepts on the falling edge, done 4 falling edges later.
    logic [15:0] mem [0:65535];
    logic        mbusy = 1'b0;
    logic        mhang = 1'b0;
    logic        mwe = 1'b0;
    logic        m_oe = 1'b0;
    logic [15:0] maddr_l = '0;
    logic [63:0] mrd = '0;
    int          mcnt = 0;

    assign m_data = m_oe ? mrd : {64{1'bz}};

    always @(negedge clk) begin
        if (m_doneM) begin
            m_doneM        <= 1'b0;
            m_input_readyM <= 1'b0;
            m_oe           <= 1'b0;
            mbusy          <= 1'b0;
            m_readyM       <= 1'b1;
        end else if (mbusy) begin
            if (!mhang) begin
                if (mcnt == 1) begin
                    m_doneM <= 1'b1;
                    if (!mwe) begin
                        m_oe           <= 1'b1;
                        m_input_readyM <= 1'b1;
                        mrd <= {mem[maddr_l + 16'd3], mem[maddr_l + 16'd2],
                                mem[maddr_l + 16'd1], mem[maddr_l]};
                    end
                end
                mcnt <= mcnt - 1;
            end
        end else if (m_readM || m_writeM) begin
            mbusy    <= 1'b1;
            m_readyM <= 1'b0;
            mcnt     <= 4;
            mwe      <= m_writeM;
            maddr_l  <= m_address;
            if (m_writeM) begin
                mem[m_address]          <= m_data[15:0];
                mem[m_address + 16'd1]  <= m_data[31:16];
                mem[m_address + 16'd2]  <= m_data[47:32];
                mem[m_address + 16'd3]  <= m_data[63:48];
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
        chk("excl_op", {63'b0, m_readM & m_writeM}, 64'd0);
        chk("excl_done", {63'b0, ic_done & dc_done}, 64'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic do_txn(input bit is_dc, input bit we, input logic [15:0] addr,
                          input logic [63:0] wd, output logic [15:0] seen_addr,
                          output bit seen_we, output int cyc, output logic [63:0] rd);
        seen_addr = 16'hDEAD;
        seen_we   = 1'b0;
        cyc       = 0;
        rd        = '0;
        if (is_dc) begin
            dc_req = 1'b1; dc_we = we; dc_addr = addr; dc_wdata = wd;
        end else begin
            ic_req = 1'b1; ic_addr = addr;
        end
        for (int i = 1; i <= 40; i++) begin
            step();
            if (m_readM || m_writeM) begin
                seen_addr = m_address;
                seen_we   = m_writeM;
            end
            chk("wrong_done", {63'b0, is_dc ? ic_done : dc_done}, 64'd0);
            if (is_dc ? dc_done : ic_done) begin
                cyc = i;
                rd  = is_dc ? dc_rdata : ic_rdata;
                break;
            end
        end
        ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
        step();
    endtask

    // order bit k = 1 when the k-th completed grant went to DC
    task automatic run_both(input int n, input bit drop, output logic [3:0] order, output int got);
        ic_req = 1'b1; ic_addr = 16'h0010;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 16'h0020;
        got = 0;
        order = '0;
        for (int i = 0; i < 80 && got < n; i++) begin
            step();
            if (dc_done) begin
                order[got] = 1'b1;
                got++;
                if (drop) dc_req = 1'b0;
            end else if (ic_done) begin
                order[got] = 1'b0;
                got++;
                if (drop) ic_req = 1'b0;
            end
        end
        ic_req = 1'b0; dc_req = 1'b0;
        step();
    endtask

    typedef struct {
        bit          is_dc;
        bit          we;
        logic [15:0] addr;
        logic [63:0] wdata;
        logic [15:0] exp_maddr;
        logic [63:0] exp_rdata;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [15:0] sa;
        bit          sw;
        int          cyc;
        logic [63:0] rd;
        logic [3:0]  order;
        int          got;
        int          extra;
        bit          done_seen;
        bit          issued;

        for (int i = 0; i < 65536; i++) mem[i] = 16'h1000 + 16'(i);

        vecs[0] = '{1'b0, 1'b0, 16'h0025, 64'h0, 16'h0024, 64'h1027_1026_1025_1024};
        vecs[1] = '{1'b1, 1'b1, 16'h0041, 64'h4444_3333_2222_1111, 16'h0040, 64'h0};
        vecs[2] = '{1'b1, 1'b0, 16'h0040, 64'h0, 16'h0040, 64'h4444_3333_2222_1111};
        vecs[3] = '{1'b0, 1'b0, 16'h0043, 64'h0, 16'h0040, 64'h4444_3333_2222_1111};
        vecs[4] = '{1'b1, 1'b0, 16'hFFFF, 64'h0, 16'hFFFC, 64'h0FFF_0FFE_0FFD_0FFC};
        vecs[5] = '{1'b1, 1'b1, 16'h0002, 64'hDEAD_BEEF_CAFE_F00D, 16'h0000, 64'h0FFF_0FFE_0FFD_0FFC};
        vecs[6] = '{1'b0, 1'b0, 16'h0001, 64'h0, 16'h0000, 64'hDEAD_BEEF_CAFE_F00D};
        vecs[7] = '{1'b1, 1'b0, 16'h0024, 64'h0, 16'h0024, 64'h1027_1026_1025_1024};

        // Reset state
        step();
        step();
        chk("rst_readM", {63'b0, m_readM}, 64'd0);
        chk("rst_writeM", {63'b0, m_writeM}, 64'd0);
        chk("rst_address", {48'b0, m_address}, 64'd0);
        chk("rst_ic_done", {63'b0, ic_done}, 64'd0);
        chk("rst_dc_done", {63'b0, dc_done}, 64'd0);
        chk("rst_ic_rdata", ic_rdata, 64'd0);
        chk("rst_dc_rdata", dc_rdata, 64'd0);
        chk("rst_err", {63'b0, err}, 64'd0);
        reset_n = 1'b1;
        step();

        // Directed single transactions
        for (int v = 0; v < 8; v++) begin
            do_txn(vecs[v].is_dc, vecs[v].we, vecs[v].addr, vecs[v].wdata, sa, sw, cyc, rd);
            chk($sformatf("v%0d_maddr", v), {48'b0, sa}, {48'b0, vecs[v].exp_maddr});
            chk($sformatf("v%0d_op", v), {63'b0, sw}, {63'b0, vecs[v].we});
            chk($sformatf("v%0d_latency", v), 64'(cyc), 64'd6);
            chk($sformatf("v%0d_rdata", v), rd, vecs[v].exp_rdata);
        end

        // Tie after reset: DC first, then IC; after a lone DC grant, tie goes to IC
        do_reset();
        run_both(2, 1'b1, order, got);
        chk("tie1_count", 64'(got), 64'd2);
        chk("tie1_order", {60'b0, order}, 64'b0001);
        do_txn(1'b1, 1'b0, 16'h0040, 64'h0, sa, sw, cyc, rd);
        chk("lone_dc_rdata", rd, 64'h4444_3333_2222_1111);
        run_both(2, 1'b1, order, got);
        chk("tie2_count", 64'(got), 64'd2);
        chk("tie2_order", {60'b0, order}, 64'b0010);

        // Both held continuously: strict alternation starting with DC
        do_reset();
        run_both(4, 1'b0, order, got);
        chk("alt_count", 64'(got), 64'd4);
        chk("alt_order", {60'b0, order}, 64'b0101);
        chk("alt_ic_rdata", ic_rdata, 64'h1013_1012_1011_1010);
        chk("alt_dc_rdata", dc_rdata, 64'h1023_1022_1021_1020);

        // Watchdog: memory never signals done
        mhang = 1'b1;
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 16'h0100;
        cyc = 0;
        for (int i = 1; i <= 50; i++) begin
            step();
            if (i == 20) chk("wd_err_early", {63'b0, err}, 64'd0);
            if (dc_done) begin
                cyc = i;
                break;
            end
        end
        chk("wd_cycles", 64'(cyc), 64'd33);
        chk("wd_err_set", {63'b0, err}, 64'd1);
        chk("wd_rdata_kept", dc_rdata, 64'h1023_1022_1021_1020);
        dc_req = 1'b0;
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (dc_done) extra++;
        end
        chk("wd_done_once", 64'(extra), 64'd0);
        mhang = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("wd_err_sticky", {63'b0, err}, 64'd1);

        // Reset during WAIT, memory still busy afterwards
        dc_req = 1'b1; dc_we = 1'b0; dc_addr = 16'h0024;
        step();
        step();
        step();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_readM", {63'b0, m_readM}, 64'd0);
        chk("mid_rst_address", {48'b0, m_address}, 64'd0);
        chk("mid_rst_dc_done", {63'b0, dc_done}, 64'd0);
        chk("mid_rst_dc_rdata", dc_rdata, 64'd0);
        chk("mid_rst_err", {63'b0, err}, 64'd0);
        step();
        reset_n = 1'b1;
        done_seen = 1'b0;
        issued = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (m_doneM) done_seen = 1'b1;
            if (m_readM) begin
                issued = 1'b1;
                break;
            end
        end
        chk("drain_issued", {63'b0, issued}, 64'd1);
        chk("drain_before_issue", {63'b0, done_seen}, 64'd1);
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (dc_done) begin
                cyc = i;
                break;
            end
        end
        dc_req = 1'b0;
        chk("drain_done", {63'b0, cyc != 0}, 64'd1);
        chk("drain_rdata", dc_rdata, 64'h1027_1026_1025_1024);
        chk("drain_err", {63'b0, err}, 64'd0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
